// File: rtl/apb_write_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ write requesters onto one APB master port; optional ACCESS timeout via APB_WR_ARB_TIMEOUT_EN.
// Latency: SETUP + >=1 ACCESS cycle per transfer, back-to-back grants with no idle cycle; req_done/req_err are combinational.
// Backpressure: PREADY=0 holds ACCESS (bounded by TIMEOUT_CYCLES when the timeout is enabled); requesters hold req_valid until done/err.
module apb_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PADDR,
    output logic [31:0]           PWDATA,
    input  logic                  PREADY
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     last_grant;
    logic [NUM_REQ-1:0] arb_req;
    logic              arb_hit;
    logic [IW-1:0]     arb_idx;
    int                arb_scan;
    logic              load;
    logic              xfer_end;
    logic              timeout_hit;
    logic [NUM_REQ-1:0] grant_oh;

    // last_grant doubles as the index of the transfer in flight
    assign grant_oh = NUM_REQ'(1) << last_grant;
    assign xfer_end = (state == ACCESS) && PREADY;

    always_comb begin
        arb_req  = (state == ACCESS) ? (req_valid & ~grant_oh) : req_valid;
        arb_hit  = 1'b0;
        arb_idx  = '0;
        arb_scan = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_scan = (int'(last_grant) + k) % NUM_REQ;
            if (!arb_hit && arb_req[arb_scan]) begin
                arb_hit = 1'b1;
                arb_idx = IW'(arb_scan);
            end
        end
    end

`ifdef APB_WR_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign timeout_hit = (state == ACCESS) && !PREADY && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign req_err     = (timeout_hit && !PRESET) ? grant_oh : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET)
            to_cnt <= '0;
        else if (load)
            to_cnt <= '0;
        else if ((state == ACCESS) && !PREADY)
            to_cnt <= to_cnt + 8'd1;
    end
`else
    assign timeout_hit = 1'b0;
    assign req_err     = '0;
`endif

    assign req_done = (xfer_end && !PRESET) ? grant_oh : '0;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    if (arb_hit) begin
                        state_nxt = SETUP;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            state   <= state_nxt;
            PSEL    <= (state_nxt != IDLE);
            PENABLE <= (state_nxt == ACCESS);
            PWRITE  <= (state_nxt != IDLE);
            if (load) begin
                last_grant <= arb_idx;
                PADDR      <= req_addr[int'(arb_idx)*32 +: 32];
                PWDATA     <= req_wdata[int'(arb_idx)*32 +: 32];
            end
        end
    end

endmodule

// File: tb/tb_apb_write_arbiter.sv
// Directed-vector bench for apb_write_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=4).
module tb_apb_write_arbiter;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic [3:0]   req_valid;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_done;
    logic [3:0]   req_err;
    logic         PSEL, PENABLE, PWRITE;
    logic [31:0]  PADDR, PWDATA;
    logic         PREADY;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [3:0] drop;
    logic [31:0] exp_v;

    apb_write_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESET = 1'b1; req_valid = '0; PREADY = 1'b0;
        req_addr = '0; req_wdata = '0;

        // reset state, with a request already pending
        req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'hDEADBEEF;
        req_valid = 4'b0001; PREADY = 1'b1;
        step; step; #1;
        check("rst_psel",    32'(PSEL),    32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite",  32'(PWRITE),  32'd0);
        check("rst_paddr",   PADDR,        32'd0);
        check("rst_pwdata",  PWDATA,       32'd0);
        check("rst_done",    32'(req_done), 32'd0);
        check("rst_err",     32'(req_err),  32'd0);
        PRESET = 1'b0;

        // single zero-wait transfer
        step; #1;
        check("s_psel",    32'(PSEL),    32'd1);
        check("s_penable", 32'(PENABLE), 32'd0);
        check("s_pwrite",  32'(PWRITE),  32'd1);
        check("s_paddr",   PADDR,        32'h10);
        check("s_pwdata",  PWDATA,       32'hDEADBEEF);
        check("s_done_setup", 32'(req_done), 32'd0);
        step; #1;
        check("s_acc_penable", 32'(PENABLE), 32'd1);
        check("s_acc_done",    32'(req_done), 32'b0001);
        check("s_acc_paddr",   PADDR,         32'h10);
        step; req_valid = '0; #1;
        check("s_idle_psel",  32'(PSEL),  32'd0);
        check("s_idle_pwrite", 32'(PWRITE), 32'd0);
        check("s_idle_paddr", PADDR,      32'h10);
        check("s_idle_pwdata", PWDATA,    32'hDEADBEEF);
        check("s_idle_done",  32'(req_done), 32'd0);

        // two wait states
        req_addr[31:0] = 32'h20; req_wdata[31:0] = 32'h12345678;
        req_valid = 4'b0001; PREADY = 1'b0;
        step; #1;
        check("w_setup_paddr", PADDR, 32'h20);
        for (int a = 1; a <= 3; a++) begin
            step; PREADY = (a == 3); #1;
            check("w_psel",    32'(PSEL),    32'd1);
            check("w_penable", 32'(PENABLE), 32'd1);
            check("w_paddr",   PADDR,        32'h20);
            check("w_pwdata",  PWDATA,       32'h12345678);
            check("w_done",    32'(req_done), (a == 3) ? 32'd1 : 32'd0);
        end
        step; req_valid = '0; #1;
        check("w_idle_psel", 32'(PSEL), 32'd0);

        // all four requesters together after reset
        PRESET = 1'b1; step;
        PRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr[32*i +: 32]  = 32'h100 + 32'(4*i);
            req_wdata[32*i +: 32] = 32'hA0 + 32'(i);
        end
        req_valid = 4'hF; PREADY = 1'b1; drop = '0;
        for (int c = 1; c <= 8; c++) begin
            step; req_valid = req_valid & ~drop; #1;
            check("rr_psel",    32'(PSEL),    32'd1);
            check("rr_penable", 32'(PENABLE), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c % 2 == 1) begin
                check("rr_paddr",  PADDR,  32'h100 + 32'(4*((c-1)/2)));
                check("rr_pwdata", PWDATA, 32'hA0 + 32'((c-1)/2));
                exp_v = 32'd0;
            end else begin
                exp_v = 32'd1 << (c/2 - 1);
            end
            check("rr_done", 32'(req_done), exp_v);
            drop = req_done;
        end
        step; req_valid = req_valid & ~drop; #1;
        check("rr_idle_psel", 32'(PSEL), 32'd0);

        // requesters 1 and 3 permanently high
        req_valid = 4'b1010; PREADY = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step; #1;
            exp_v = (((c-1)/2) % 2 == 0) ? 32'd1 : 32'd3;
            if (c % 2 == 1)
                check("alt_paddr", PADDR, 32'h100 + 4*exp_v);
            else
                check("alt_done", 32'(req_done), 32'd1 << exp_v);
        end
        // requester 1 granted again, then drops valid before its ACCESS
        step; req_valid = '0; #1;
        check("drop_setup_paddr", PADDR,        32'h104);
        check("drop_setup_pen",   32'(PENABLE), 32'd0);
        step; #1;
        check("drop_done", 32'(req_done), 32'b0010);
        step; #1;
        check("drop_idle_psel", 32'(PSEL), 32'd0);

        // reset during ACCESS of requester 2
        req_valid = 4'b0100; PREADY = 1'b0;
        step; #1;
        check("mr_setup_paddr", PADDR, 32'h108);
        step; #1;
        check("mr_acc_penable", 32'(PENABLE), 32'd1);
        check("mr_acc_done",    32'(req_done), 32'd0);
        PRESET = 1'b1; PREADY = 1'b1; #1;
        check("mr_forced_done", 32'(req_done), 32'd0);
        step; #1;
        check("mr_psel",  32'(PSEL), 32'd0);
        check("mr_paddr", PADDR,     32'd0);
        PRESET = 1'b0; req_valid = 4'b0101;
        step; #1;
        check("mr_first_grant", PADDR, 32'h100);
        step; #1;
        check("mr_first_done", 32'(req_done), 32'b0001);
        step; req_valid = 4'b0100; #1;
        check("mr_second_grant", PADDR, 32'h108);
        step; #1;
        check("mr_second_done", 32'(req_done), 32'b0100);
        step; req_valid = '0; #1;
        check("mr_idle_psel", 32'(PSEL), 32'd0);

        // ACCESS with PREADY held low
        req_valid = 4'b0001; PREADY = 1'b0;
        step; #1;
        check("to_setup_paddr", PADDR, 32'h100);
`ifdef APB_WR_ARB_TIMEOUT_EN
        for (int a = 1; a <= 4; a++) begin
            step; #1;
            check("to_penable", 32'(PENABLE), 32'd1);
            check("to_err",     32'(req_err),  (a == 4) ? 32'd1 : 32'd0);
            check("to_done",    32'(req_done), 32'd0);
        end
        step; req_valid = '0; #1;
        check("to_after_psel", 32'(PSEL),    32'd0);
        check("to_after_err",  32'(req_err), 32'd0);
`else
        for (int a = 1; a <= 6; a++) begin
            step; #1;
            check("nto_penable", 32'(PENABLE), 32'd1);
            check("nto_err",     32'(req_err),  32'd0);
            check("nto_done",    32'(req_done), 32'd0);
        end
        PREADY = 1'b1; #1;
        check("nto_late_done", 32'(req_done), 32'd1);
        step; req_valid = '0; #1;
        check("nto_idle_psel", 32'(PSEL), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
